// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the SIPO deserializer: serial input side, parallel
// valid/ready output side, and the overrun status/clear pair.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             si;
  logic             si_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic             clr_overrun;
  logic [CNT_W-1:0] bit_cnt;

  // Producer of the serial stream and consumer of the parallel words.
  modport master (
    output si, si_valid, frame_sync, po_ready, clr_overrun,
    input  po, po_valid, overrun, bit_cnt
  );

  // The deserializer itself.
  modport slave (
    input  si, si_valid, frame_sync, po_ready, clr_overrun,
    output po, po_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver. Assembles MSB-first WIDTH-bit words from
// a qualified 1-bit stream, realigns on frame_sync, and presents finished
// words through a one-entry valid/ready holding register. Words that arrive
// while the holding register is still occupied are dropped and flagged by a
// sticky overrun bit.
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  sipo_deserializer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_po;
  logic             r_po_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_last_bit;
  logic             w_xfer;
  logic             w_load;
  logic             w_drop;

  // Word completion and holding-register decisions for this edge.
  // A frame_sync bit always starts a new word, so it can never complete one.
  always_comb begin
    w_word     = {r_shreg[WIDTH-2:0], bus.si};
    w_last_bit = 1'b0;
    w_xfer     = 1'b0;
    w_load     = 1'b0;
    w_drop     = 1'b0;
    w_last_bit = bus.si_valid && !bus.frame_sync && (r_bit_cnt == LAST_CNT);
    w_xfer     = r_po_valid && bus.po_ready;
    w_load     = w_last_bit && (!r_po_valid || w_xfer);
    w_drop     = w_last_bit && !w_load;
  end

  // Shift register and bit counter: shift on valid bits, realign on frame_sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (bus.frame_sync) begin
      if (bus.si_valid) begin
        r_shreg   <= {{(WIDTH-1){1'b0}}, bus.si};
        r_bit_cnt <= CNT_W'(1);
      end else begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
      end
    end else if (bus.si_valid) begin
      r_shreg   <= w_word;
      r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  // Holding register: load a finished word when empty or being drained,
  // otherwise hold the current word untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_po       <= '0;
      r_po_valid <= 1'b0;
    end else if (w_load) begin
      r_po       <= w_word;
      r_po_valid <= 1'b1;
    end else if (w_xfer) begin
      r_po_valid <= 1'b0;
    end
  end

  // Sticky overrun: a dropped word sets it and beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.po       = r_po;
  assign bus.po_valid = r_po_valid;
  assign bus.overrun  = r_overrun;
  assign bus.bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed testbench for sipo_deserializer (WIDTH=4).
module tb_sipo_deserializer;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  sipo_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.si       = b;
    bus.si_valid = 1'b1;
    tick();
    bus.si_valid = 1'b0;
  endtask

  task automatic idle();
    bus.si_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    bus.po_ready = 1'b1;
    idle();
    bus.po_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (bus.po !== 4'h0) begin n_fail++; $display("FAIL reset_po got=%h exp=0", bus.po); end
    n_run++;
    if (bus.po_valid !== 1'b0) begin n_fail++; $display("FAIL reset_po_valid got=%b exp=0", bus.po_valid); end
    n_run++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    n_run++;
    if (bus.bit_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_bit_cnt got=%0d exp=0", bus.bit_cnt); end
  endtask

  task automatic test_basic_word();
    bus.po_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    n_run++;
    if (bus.bit_cnt !== 2'd2) begin n_fail++; $display("FAIL basic_cnt2 got=%0d exp=2", bus.bit_cnt); end
    n_run++;
    if (bus.po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", bus.po_valid); end
    send_bit(1'b1);
    send_bit(1'b1);
    n_run++;
    if (bus.po !== 4'b1011) begin n_fail++; $display("FAIL basic_po got=%b exp=1011", bus.po); end
    n_run++;
    if (bus.po_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus.po_valid); end
    n_run++;
    if (bus.bit_cnt !== 2'd0) begin n_fail++; $display("FAIL basic_cnt_wrap got=%0d exp=0", bus.bit_cnt); end
    drain();
    n_run++;
    if (bus.po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid got=%b exp=0", bus.po_valid); end
    n_run++;
    if (bus.po !== 4'b1011) begin n_fail++; $display("FAIL basic_drain_po_hold got=%b exp=1011", bus.po); end
  endtask

  task automatic test_stream();
    logic [11:0] pattern;
    logic [3:0]  words [3];
    pattern = 12'b1010_0110_1111;
    words   = '{4'hA, 4'h6, 4'hF};
    bus.po_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.si       = pattern[11-i];
      bus.si_valid = 1'b1;
      tick();
      n_run++;
      if (bus.po_valid !== ((i % 4) == 3)) begin
        n_fail++;
        $display("FAIL stream_valid bit=%0d got=%b exp=%b", i, bus.po_valid, ((i % 4) == 3));
      end
      if ((i % 4) == 3) begin
        n_run++;
        if (bus.po !== words[i/4]) begin
          n_fail++;
          $display("FAIL stream_po word=%0d got=%h exp=%h", i/4, bus.po, words[i/4]);
        end
      end
    end
    idle();
    n_run++;
    if (bus.po_valid !== 1'b0) begin n_fail++; $display("FAIL stream_final_valid got=%b exp=0", bus.po_valid); end
    n_run++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL stream_overrun got=%b exp=0", bus.overrun); end
    bus.po_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.po_ready = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_run++;
    if (bus.po !== 4'h5 || bus.po_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first got=%h/%b exp=5/1", bus.po, bus.po_valid);
    end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    n_run++;
    if (bus.po !== 4'h5) begin n_fail++; $display("FAIL b2b_hold got=%h exp=5", bus.po); end
    // Consumer takes word 5 on the same edge that completes word E.
    bus.po_ready = 1'b1;
    send_bit(1'b0);
    bus.po_ready = 1'b0;
    n_run++;
    if (bus.po !== 4'hE || bus.po_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_reload got=%h/%b exp=e/1", bus.po, bus.po_valid);
    end
    n_run++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
    drain();
  endtask

  task automatic test_overrun();
    bus.po_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    n_run++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before got=%b exp=0", bus.overrun); end
    send_bit(1'b1);
    n_run++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    n_run++;
    if (bus.po !== 4'hC || bus.po_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_po_hold got=%h/%b exp=c/1", bus.po, bus.po_valid);
    end
    bus.clr_overrun = 1'b1;
    idle();
    bus.clr_overrun = 1'b0;
    n_run++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end
    // Drop coinciding with a clear: the set must win.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus.clr_overrun = 1'b1;
    send_bit(1'b1);
    bus.clr_overrun = 1'b0;
    n_run++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got=%b exp=1", bus.overrun); end
    n_run++;
    if (bus.po !== 4'hC) begin n_fail++; $display("FAIL ovr_po_still got=%h exp=c", bus.po); end
    bus.clr_overrun = 1'b1;
    idle();
    bus.clr_overrun = 1'b0;
    drain();
  endtask

  task automatic test_frame_sync();
    bus.po_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    n_run++;
    if (bus.bit_cnt !== 2'd2) begin n_fail++; $display("FAIL fs_cnt_pre got=%0d exp=2", bus.bit_cnt); end
    bus.frame_sync = 1'b1;
    send_bit(1'b0);
    bus.frame_sync = 1'b0;
    n_run++;
    if (bus.bit_cnt !== 2'd1) begin n_fail++; $display("FAIL fs_cnt_restart got=%0d exp=1", bus.bit_cnt); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_run++;
    if (bus.po !== 4'b0101 || bus.po_valid !== 1'b1) begin
      n_fail++; $display("FAIL fs_word got=%b/%b exp=0101/1", bus.po, bus.po_valid);
    end
    drain();
    // frame_sync without a bit just discards the partial word.
    send_bit(1'b1);
    bus.frame_sync = 1'b1;
    idle();
    bus.frame_sync = 1'b0;
    n_run++;
    if (bus.bit_cnt !== 2'd0) begin n_fail++; $display("FAIL fs_idle_cnt got=%0d exp=0", bus.bit_cnt); end
    n_run++;
    if (bus.po !== 4'b0101 || bus.po_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL fs_idle_out got=%b/%b/%b exp=0101/0/0", bus.po, bus.po_valid, bus.overrun);
    end
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    n_run++;
    if (bus.po !== 4'h3) begin n_fail++; $display("FAIL fs_idle_next got=%h exp=3", bus.po); end
    drain();
  endtask

  task automatic test_gaps();
    logic [3:0] word;
    int         gaps [4];
    word = 4'h9;
    gaps = '{0, 1, 2, 3};
    bus.po_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) idle();
      n_run++;
      if (bus.po_valid !== 1'b0 || bus.bit_cnt !== 2'(i)) begin
        n_fail++; $display("FAIL gap_state bit=%0d got=%b/%0d exp=0/%0d", i, bus.po_valid, bus.bit_cnt, i);
      end
      send_bit(word[3-i]);
    end
    n_run++;
    if (bus.po !== 4'h9 || bus.po_valid !== 1'b1) begin
      n_fail++; $display("FAIL gap_word got=%h/%b exp=9/1", bus.po, bus.po_valid);
    end
  endtask

  task automatic test_midword_reset();
    // po_valid is still 1 from the previous test; reset must clear it.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst          = 1'b1;
    bus.si       = 1'b1;
    bus.si_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.si_valid = 1'b0;
    n_run++;
    if (bus.po_valid !== 1'b0 || bus.po !== 4'h0 || bus.bit_cnt !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid got=%b/%h/%0d exp=0/0/0", bus.po_valid, bus.po, bus.bit_cnt);
    end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    n_run++;
    if (bus.po_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid got=%b exp=0", bus.po_valid); end
    send_bit(1'b1);
    n_run++;
    if (bus.po !== 4'h5 || bus.po_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_new_word got=%h/%b exp=5/1", bus.po, bus.po_valid);
    end
  endtask

  initial begin
    bus.si          = 1'b0;
    bus.si_valid    = 1'b0;
    bus.frame_sync  = 1'b0;
    bus.po_ready    = 1'b0;
    bus.clr_overrun = 1'b0;
    test_reset();
    test_basic_word();
    test_stream();
    test_back_to_back();
    test_overrun();
    test_frame_sync();
    test_gaps();
    test_midword_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
